// File: rtl/eth_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// eth_pkg: shared types and constants for the Ethernet tx scheduler
// Rev 1.0
// ---------------------------------------------------------------
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_EN = 3'd2,
    SEND    = 3'd3,
    IFG     = 3'd4
  } state_t;

  typedef enum logic {
    SRC_ARP = 1'b0,
    SRC_UDP = 1'b1
  } src_t;

  localparam int unsigned IFG_DEFAULT = 12;
  localparam int unsigned TIMER_W     = 16;

endpackage
`default_nettype wire

// File: rtl/eth_tx_timer.sv
`default_nettype none
// ---------------------------------------------------------------
// eth_tx_timer: loadable down-counter, o_expire high while count==1
// Rev 1.0
// ---------------------------------------------------------------
module eth_tx_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expire
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so a spent count never re-fires
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == W'(1));

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// ---------------------------------------------------------------
// eth_tx_sched: arbitrates the MAC tx port between ARP and UDP senders
// Rev 1.0
// ---------------------------------------------------------------
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES    = IFG_DEFAULT,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned MAX_FRAME     = 1600,
  parameter int unsigned ARP_BURST     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arp_req,
  input  logic        i_udp_req,
  output logic        o_arp_start,
  output logic        o_udp_start,
  input  logic [7:0]  i_arp_tx_data,
  input  logic        i_arp_tx_en,
  input  logic [7:0]  i_udp_tx_data,
  input  logic        i_udp_tx_en,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_en,
  output logic        o_arp_pend,
  output logic        o_udp_pend,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_frame_cnt
);

  localparam logic [3:0]         BURST_MAX = 4'(ARP_BURST);
  localparam logic [TIMER_W-1:0] TO_LOAD   = TIMER_W'(START_TIMEOUT);
  // The cycle that enters SEND already carries the first byte
  localparam logic [TIMER_W-1:0] MF_LOAD   = TIMER_W'(MAX_FRAME - 1);
  localparam logic [TIMER_W-1:0] IFG_LOAD  = TIMER_W'(IFG_CYCLES);

  state_t        state_q, state_d;
  src_t          sel_q, sel_d;
  logic          arp_pend_q, arp_pend_d, udp_pend_q, udp_pend_d;
  logic          arp_clr, udp_clr;
  logic [3:0]    burst_q, burst_d;
  logic          err_q, err_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          sel_en;
  logic [7:0]    sel_data;
  logic          active;
  logic          tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic          tmr_expire;

  eth_tx_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_expire   (tmr_expire)
  );

  always_comb begin
    sel_en   = (sel_q == SRC_UDP) ? i_udp_tx_en   : i_arp_tx_en;
    sel_data = (sel_q == SRC_UDP) ? i_udp_tx_data : i_arp_tx_data;
    active   = (state_q == WAIT_EN) || (state_q == SEND);
    tx_en_d  = active && sel_en;
    tx_data_d = active ? sel_data : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    burst_d     = burst_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    arp_clr     = 1'b0;
    udp_clr     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      IDLE: begin
        if (arp_pend_q || udp_pend_q) begin
          state_d = START;
          if (udp_pend_q && (!arp_pend_q || burst_q == BURST_MAX)) begin
            sel_d   = SRC_UDP;
            burst_d = 4'd0;
          end else begin
            sel_d = SRC_ARP;
            if (udp_pend_q) burst_d = burst_q + 4'd1;
          end
        end
      end
      START: begin
        state_d  = WAIT_EN;
        arp_clr  = (sel_q == SRC_ARP);
        udp_clr  = (sel_q == SRC_UDP);
        tmr_load = 1'b1;
        tmr_val  = TO_LOAD;
      end
      WAIT_EN: begin
        if (sel_en) begin
          state_d  = SEND;
          tmr_load = 1'b1;
          tmr_val  = MF_LOAD;
        end else if (tmr_expire) begin
          state_d  = IFG;
          err_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = IFG_LOAD;
        end
      end
      SEND: begin
        if (!sel_en) begin
          state_d     = IFG;
          frame_cnt_d = frame_cnt_q + 16'd1;
          tmr_load    = 1'b1;
          tmr_val     = IFG_LOAD;
        end else if (tmr_expire) begin
          state_d  = IFG;
          err_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = IFG_LOAD;
        end
      end
      IFG: begin
        if (tmr_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!udp_pend_q) burst_d = 4'd0;
    arp_pend_d = (arp_pend_q && !arp_clr) || i_arp_req;
    udp_pend_d = (udp_pend_q && !udp_clr) || i_udp_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= SRC_ARP;
      arp_pend_q  <= 1'b0;
      udp_pend_q  <= 1'b0;
      burst_q     <= 4'd0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      arp_pend_q  <= arp_pend_d;
      udp_pend_q  <= udp_pend_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign o_arp_start = (state_q == START) && (sel_q == SRC_ARP);
  assign o_udp_start = (state_q == START) && (sel_q == SRC_UDP);
  assign o_tx_en     = tx_en_q;
  assign o_tx_data   = tx_data_q;
  assign o_arp_pend  = arp_pend_q;
  assign o_udp_pend  = udp_pend_q;
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sched.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_eth_tx_sched: scoreboard bench for the ARP/UDP tx scheduler
// Rev 1.0
// ---------------------------------------------------------------
module tb_eth_tx_sched;
  import eth_pkg::*;

  localparam int IFG = 12;
  localparam int TO  = 64;
  localparam int MF  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_arp_req = 1'b0, i_udp_req = 1'b0;
  logic        o_arp_start, o_udp_start;
  logic [7:0]  i_arp_tx_data = 8'h00, i_udp_tx_data = 8'h00;
  logic        i_arp_tx_en = 1'b0, i_udp_tx_en = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_en, o_arp_pend, o_udp_pend, o_busy, o_err;
  logic [15:0] o_frame_cnt;

  eth_tx_sched #(
    .IFG_CYCLES(IFG), .START_TIMEOUT(TO), .MAX_FRAME(MF), .ARP_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_arp_req(i_arp_req), .i_udp_req(i_udp_req),
    .o_arp_start(o_arp_start), .o_udp_start(o_udp_start),
    .i_arp_tx_data(i_arp_tx_data), .i_arp_tx_en(i_arp_tx_en),
    .i_udp_tx_data(i_udp_tx_data), .i_udp_tx_en(i_udp_tx_en),
    .o_tx_data(o_tx_data), .o_tx_en(o_tx_en),
    .o_arp_pend(o_arp_pend), .o_udp_pend(o_udp_pend),
    .o_busy(o_busy), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int cyc; } exp_byte_t;
  exp_byte_t byte_q[$];
  bit        grant_q[$];   // 0 = ARP, 1 = UDP
  int total = 0;
  int bad   = 0;

  // Every byte on the MAC side must match a byte the sender model drove, one cycle later
  always @(negedge clk) begin
    if (o_tx_en === 1'b1) begin
      total++;
      if (byte_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got data %02h at cycle %0d, want no tx_en", o_tx_data, cyc);
      end else begin
        exp_byte_t e;
        e = byte_q.pop_front();
        if (o_tx_data !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL tx_byte: got %02h at cycle %0d, want %02h at cycle %0d",
                   o_tx_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_arp_start === 1'b1 || o_udp_start === 1'b1) begin
      total++;
      if (o_arp_start === 1'b1 && o_udp_start === 1'b1) begin
        bad++;
        $display("FAIL grant_both: got both starts at cycle %0d, want one", cyc);
      end else if (grant_q.size() == 0) begin
        bad++;
        $display("FAIL grant_unexpected: got %s start at cycle %0d, want none",
                 o_udp_start ? "udp" : "arp", cyc);
      end else begin
        bit e;
        e = grant_q.pop_front();
        if (o_udp_start !== e) begin
          bad++;
          $display("FAIL grant_order: got %s start at cycle %0d, want %s",
                   o_udp_start ? "udp" : "arp", cyc, e ? "udp" : "arp");
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit arp, input bit udp, output int r);
    tick();
    i_arp_req = arp;
    i_udp_req = udp;
    r = cyc;
    tick();
    i_arp_req = 1'b0;
    i_udp_req = 1'b0;
  endtask

  task automatic wait_start(input bit src, output int s);
    s = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((src ? o_udp_start : o_arp_start) === 1'b1) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      total++;
      bad++;
      $display("FAIL start_wait: got no %s start within 100 cycles, want one", src ? "udp" : "arp");
    end
  endtask

  // Sender model: en rises 'dly' cycles after the start cycle, stays high 'len' cycles
  task automatic send_frame(input bit src, input int dly, input int len, input int keep,
                            input logic [7:0] base, input bit noise, output int f);
    for (int i = 0; i < dly; i++) begin
      tick();
      if (noise) begin
        i_udp_tx_en   = 1'b1;
        i_udp_tx_data = 8'hEE;
      end
    end
    for (int i = 0; i < len; i++) begin
      exp_byte_t e;
      if (src) begin
        i_udp_tx_en   = 1'b1;
        i_udp_tx_data = base + 8'(i);
      end else begin
        i_arp_tx_en   = 1'b1;
        i_arp_tx_data = base + 8'(i);
      end
      if (noise) begin
        i_udp_tx_en   = i[0];
        i_udp_tx_data = 8'hE0 ^ 8'(i);
      end
      if (i < keep) begin
        e.data = base + 8'(i);
        e.cyc  = cyc + 1;
        byte_q.push_back(e);
      end
      tick();
    end
    i_arp_tx_en = 1'b0; i_arp_tx_data = 8'h00;
    i_udp_tx_en = 1'b0; i_udp_tx_data = 8'h00;
    f = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1);
  end

  initial begin
    int r, s, f, su;
    bit order [6];
    order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_outputs", {o_tx_en, o_tx_data, o_arp_start, o_udp_start, o_arp_pend,
                        o_udp_pend, o_busy, o_err}, 32'h0);
    chk("rst_frame_cnt", o_frame_cnt, 0);
    tick();
    rst = 1'b0;

    // Single ARP frame: 42 bytes, en 3 cycles after start
    grant_q.push_back(1'b0);
    pulse(1'b1, 1'b0, r);
    chk("arp_pend_set", o_arp_pend, 1);
    wait_start(1'b0, s);
    chk("arp_start_lat", s - r, 2);
    send_frame(1'b0, 3, 42, 42, 8'h10, 1'b0, f);
    repeat (IFG) tick();
    chk("ifg_busy_last", o_busy, 1);
    tick();
    chk("ifg_idle", o_busy, 0);
    chk("single_frame_cnt", o_frame_cnt, 1);
    chk("single_err", o_err, 0);

    // Simultaneous requests: ARP first, UDP after IFG + exit cycle + IDLE decision
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    pulse(1'b1, 1'b1, r);
    wait_start(1'b0, s);
    chk("udp_pend_hold", o_udp_pend, 1);
    send_frame(1'b0, 2, 10, 10, 8'h40, 1'b0, f);
    wait_start(1'b1, su);
    chk("udp_after_ifg", su - f, IFG + 2);
    send_frame(1'b1, 1, 8, 8, 8'h80, 1'b0, f);
    repeat (IFG + 3) tick();
    chk("simul_frame_cnt", o_frame_cnt, 3);

    // Starvation guard: ARP held requesting while UDP waits
    for (int k = 0; k < 6; k++) grant_q.push_back(order[k]);
    tick();
    i_arp_req = 1'b1;
    i_udp_req = 1'b1;
    tick();
    i_udp_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_start(order[k], s);
      if (k == 4) i_arp_req = 1'b0;
      send_frame(order[k], 1, 4, 4, 8'(8'hA0 + 8'(k * 16)), 1'b0, f);
    end
    repeat (IFG + 3) tick();
    chk("starve_frame_cnt", o_frame_cnt, 9);
    chk("starve_pend", {o_arp_pend, o_udp_pend}, 0);

    // Start timeout: UDP sender never raises en
    grant_q.push_back(1'b1);
    pulse(1'b0, 1'b1, r);
    wait_start(1'b1, s);
    repeat (TO) tick();
    chk("timeout_err_before", o_err, 0);
    tick();
    chk("timeout_err_set", o_err, 1);
    repeat (IFG - 1) tick();
    chk("timeout_ifg_busy", o_busy, 1);
    tick();
    chk("timeout_idle", o_busy, 0);
    chk("timeout_frame_cnt", o_frame_cnt, 9);

    // Reset clears the sticky error and counter
    tick();
    rst = 1'b1;
    #1;
    chk("rst2_err", o_err, 0);
    chk("rst2_frame_cnt", o_frame_cnt, 0);
    tick();
    rst = 1'b0;

    // Overrun: en held 150 cycles, only MF bytes may reach the MAC
    grant_q.push_back(1'b0);
    pulse(1'b1, 1'b0, r);
    wait_start(1'b0, s);
    send_frame(1'b0, 2, 150, MF, 8'h00, 1'b0, f);
    chk("overrun_err", o_err, 1);
    chk("overrun_frame_cnt", o_frame_cnt, 0);
    chk("overrun_idle", o_busy, 0);

    // Reset mid-frame, with a UDP request pending
    grant_q.push_back(1'b0);
    pulse(1'b1, 1'b0, r);
    wait_start(1'b0, s);
    tick();
    i_udp_req = 1'b1;
    tick();
    begin
      exp_byte_t e;
      i_udp_req     = 1'b0;
      i_arp_tx_en   = 1'b1;
      i_arp_tx_data = 8'h5A;
      e.data = 8'h5A;
      e.cyc  = cyc + 1;
      byte_q.push_back(e);
    end
    tick();
    chk("midrst_pend_before", o_udp_pend, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_tx_en", o_tx_en, 0);
    chk("midrst_outputs", {o_tx_data, o_busy, o_udp_pend, o_arp_pend, o_err}, 0);
    i_arp_tx_en   = 1'b0;
    i_arp_tx_data = 8'h00;
    tick(); tick();
    rst = 1'b0;

    // Isolation: UDP en toggles while ARP owns the port
    grant_q.push_back(1'b0);
    pulse(1'b1, 1'b0, r);
    wait_start(1'b0, s);
    send_frame(1'b0, 3, 20, 20, 8'h30, 1'b1, f);
    repeat (IFG + 3) tick();
    chk("iso_frame_cnt", o_frame_cnt, 1);
    chk("iso_err", o_err, 0);
    chk("iso_no_pend", {o_arp_pend, o_udp_pend}, 0);

    repeat (5) tick();
    chk("grant_q_drained", grant_q.size(), 0);
    chk("byte_q_drained", byte_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
